// File: rtl/udp_tx_pkg.sv
// Shared types and constants for the UDP stream sender.
// Holds the one-hot FSM state encoding, the buffer pointer width,
// the counter width and the minimum payload length used by the pad option.
package udp_tx_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned PTR_W       = 11;   // covers 0..MAX_PAYLOAD (1472)
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned LEN_W       = 16;
    localparam int unsigned MIN_PAYLOAD = 18;

    typedef enum logic [10:0] {
        IDLE      = 11'b000_0000_0001,
        ARP_REQ   = 11'b000_0000_0010,
        ARP_SEND  = 11'b000_0000_0100,
        ARP_WAIT  = 11'b000_0000_1000,
        COLLECT   = 11'b000_0001_0000,
        CHECK     = 11'b000_0010_0000,
        GEN_REQ   = 11'b000_0100_0000,
        WAIT_REQ  = 11'b000_1000_0000,
        WRITE_RAM = 11'b001_0000_0000,
        SEND      = 11'b010_0000_0000,
        GAP       = 11'b100_0000_0000
    } state_t;

endpackage

// File: rtl/udp_stream_sender_if.sv
// Byte-stream handshake into the UDP sender.
// Signals: s_data (payload byte), s_valid (byte valid), s_last (last byte of
// frame, qualified by s_valid), s_ready (sender can accept a byte).
// master = upstream byte source, slave = udp_stream_sender.
interface udp_stream_sender_if;

    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;

    modport master (
        output s_data,
        output s_valid,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_last,
        output s_ready
    );

endinterface

// File: rtl/udp_tx_payload_buf.sv
// Simple dual-port byte RAM holding one UDP payload, registered read.
// Ports: clk_i; we_i/waddr_i/wdata_i write port; raddr_i read address,
// rdata_o read data one clock after the address is presented.
module udp_tx_payload_buf
    import udp_tx_pkg::*;
#(
    parameter int unsigned DEPTH = 1472
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [PTR_W-1:0]  waddr_i,
    input  logic [BYTE_W-1:0] wdata_i,
    input  logic [PTR_W-1:0]  raddr_i,
    output logic [BYTE_W-1:0] rdata_o
);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [BYTE_W-1:0] rdata_q;

    // Storage is not reset; the pointers define which bytes are valid.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/udp_stream_sender.sv
// UDP transmit-side sender: buffers one payload from a byte stream, resolves
// the destination MAC via ARP, requests a UDP send and streams the payload
// into mac_top's TX RAM, then waits out an inter-frame gap.
// Ports: gmii_tx_clk/rst (sync, active high); s (byte stream, slave);
// arp_request_req/mac_send_end/arp_found/mac_not_exist (ARP handshake);
// almost_full (TX throttle); udp_tx_req/udp_ram_data_req/ram_wr_data/
// ram_wr_en/udp_send_data_length/udp_tx_end (mac_top UDP TX interface).
// Build option: UDP_TX_PAD_EN pads short payloads with 0x00 up to MIN_PAYLOAD.
module udp_stream_sender
    import udp_tx_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD      = 1472,
    parameter int unsigned ARP_RETRY_CYCLES = 256,
    parameter int unsigned GAP_CYCLES       = 90
) (
    input  logic                gmii_tx_clk,
    input  logic                rst,
    udp_stream_sender_if.slave  s,
    output logic                arp_request_req,
    input  logic                mac_send_end,
    input  logic                arp_found,
    input  logic                mac_not_exist,
    input  logic                almost_full,
    output logic                udp_tx_req,
    input  logic                udp_ram_data_req,
    output logic [BYTE_W-1:0]   ram_wr_data,
    output logic                ram_wr_en,
    output logic [LEN_W-1:0]    udp_send_data_length,
    input  logic                udp_tx_end
);

    localparam logic [CNT_W-1:0] ARP_LAST = CNT_W'(ARP_RETRY_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_PAYLOAD - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   xfer_len_q, xfer_len_d;
    logic               tx_end_seen_q, tx_end_seen_d;
    logic               rd_issue_q;
    logic               s_ready_q, s_ready_d;
    logic               arp_req_q, arp_req_d;
    logic               udp_tx_req_q, udp_tx_req_d;
    logic               ram_wr_en_q, ram_wr_en_d;
    logic [BYTE_W-1:0]  ram_wr_data_q, ram_wr_data_d;

    logic               accept_c;
    logic               buf_we_c;
    logic               rd_issue_c;
    logic               data_ok_c;
    logic [PTR_W-1:0]   len_sel_c;
    logic [BYTE_W-1:0]  buf_rd_data;

    assign accept_c = s_ready_q && s.s_valid;

    udp_tx_payload_buf #(
        .DEPTH (MAX_PAYLOAD)
    ) u_buf (
        .clk_i   (gmii_tx_clk),
        .we_i    (buf_we_c),
        .waddr_i (wr_ptr_q),
        .wdata_i (s.s_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (buf_rd_data)
    );

`ifdef UDP_TX_PAD_EN
    logic pad_c, pad_q;

    // Reads past the received length are replaced by zero padding.
    assign pad_c     = (rd_ptr_q >= wr_ptr_q);
    assign data_ok_c = rd_issue_q && !pad_q;
    assign len_sel_c = (wr_ptr_q < PTR_W'(MIN_PAYLOAD)) ? PTR_W'(MIN_PAYLOAD) : wr_ptr_q;

    always_ff @(posedge gmii_tx_clk) begin
        if (rst) begin
            pad_q <= 1'b0;
        end else begin
            pad_q <= pad_c;
        end
    end
`else
    assign data_ok_c = rd_issue_q;
    assign len_sel_c = wr_ptr_q;
`endif

    // Next-state, datapath and registered-output next values.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        xfer_len_d    = xfer_len_q;
        tx_end_seen_d = tx_end_seen_q;
        buf_we_c      = 1'b0;
        rd_issue_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cnt_q == ARP_LAST) state_d = ARP_REQ;
            end
            ARP_REQ: begin
                state_d = ARP_SEND;
            end
            ARP_SEND: begin
                if (mac_send_end) state_d = ARP_WAIT;
            end
            ARP_WAIT: begin
                // A held payload goes straight back to CHECK once resolved.
                if (arp_found) begin
                    state_d = (wr_ptr_q != '0) ? CHECK : COLLECT;
                end else if (cnt_q == ARP_LAST) begin
                    state_d = ARP_REQ;
                end
            end
            COLLECT: begin
                if (accept_c) begin
                    buf_we_c = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    if (s.s_last || (wr_ptr_q == PTR_LAST)) state_d = CHECK;
                end
            end
            CHECK: begin
                if (mac_not_exist) begin
                    state_d = ARP_REQ;
                end else if (!almost_full) begin
                    xfer_len_d = len_sel_c;
                    state_d    = GEN_REQ;
                end
            end
            GEN_REQ: begin
                rd_ptr_d      = '0;
                tx_end_seen_d = 1'b0;
                state_d       = WAIT_REQ;
            end
            WAIT_REQ: begin
                // First read is issued as the request is seen, so the first
                // byte lands two clocks later.
                if (udp_tx_end) tx_end_seen_d = 1'b1;
                if (udp_ram_data_req) begin
                    rd_issue_c = 1'b1;
                    rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                    state_d    = WRITE_RAM;
                end
            end
            WRITE_RAM: begin
                if (udp_tx_end) tx_end_seen_d = 1'b1;
                if (rd_ptr_q != xfer_len_q) begin
                    rd_issue_c = 1'b1;
                    rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                end else if (!rd_issue_q) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (udp_tx_end || tx_end_seen_q) state_d = GAP;
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    state_d  = COLLECT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Counter restarts on every state change and saturates.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == '1) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        s_ready_d     = (state_d == COLLECT);
        arp_req_d     = (state_d == ARP_REQ);
        udp_tx_req_d  = (state_d == GEN_REQ);
        ram_wr_en_d   = rd_issue_q;
        ram_wr_data_d = data_ok_c ? buf_rd_data : 8'h00;
    end

    // State and registered outputs.
    always_ff @(posedge gmii_tx_clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            xfer_len_q    <= '0;
            tx_end_seen_q <= 1'b0;
            rd_issue_q    <= 1'b0;
            s_ready_q     <= 1'b0;
            arp_req_q     <= 1'b0;
            udp_tx_req_q  <= 1'b0;
            ram_wr_en_q   <= 1'b0;
            ram_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            xfer_len_q    <= xfer_len_d;
            tx_end_seen_q <= tx_end_seen_d;
            rd_issue_q    <= rd_issue_c;
            s_ready_q     <= s_ready_d;
            arp_req_q     <= arp_req_d;
            udp_tx_req_q  <= udp_tx_req_d;
            ram_wr_en_q   <= ram_wr_en_d;
            ram_wr_data_q <= ram_wr_data_d;
        end
    end

    assign s.s_ready            = s_ready_q;
    assign arp_request_req      = arp_req_q;
    assign udp_tx_req           = udp_tx_req_q;
    assign ram_wr_en            = ram_wr_en_q;
    assign ram_wr_data          = ram_wr_data_q;
    assign udp_send_data_length = LEN_W'(xfer_len_q);

endmodule

// File: tb/tb_udp_stream_sender.sv
// Directed, table-driven bench for udp_stream_sender.
module tb_udp_stream_sender;

    logic        clk = 1'b0;
    logic        rst;
    logic        arp_request_req;
    logic        mac_send_end;
    logic        arp_found;
    logic        mac_not_exist;
    logic        almost_full;
    logic        udp_tx_req;
    logic        udp_ram_data_req;
    logic [7:0]  ram_wr_data;
    logic        ram_wr_en;
    logic [15:0] udp_send_data_length;
    logic        udp_tx_end;

    int n_checks = 0;
    int n_errors = 0;

    udp_stream_sender_if sif ();

    udp_stream_sender dut (
        .gmii_tx_clk          (clk),
        .rst                  (rst),
        .s                    (sif),
        .arp_request_req      (arp_request_req),
        .mac_send_end         (mac_send_end),
        .arp_found            (arp_found),
        .mac_not_exist        (mac_not_exist),
        .almost_full          (almost_full),
        .udp_tx_req           (udp_tx_req),
        .udp_ram_data_req     (udp_ram_data_req),
        .ram_wr_data          (ram_wr_data),
        .ram_wr_en            (ram_wr_en),
        .udp_send_data_length (udp_send_data_length),
        .udp_tx_end           (udp_tx_end)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n_bytes;
        logic [7:0] first;
        int         af_cycles;
        logic       mne;
        logic       early_end;
        int         exp_len;
    } frame_t;

    frame_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_len_f(input int n);
`ifdef UDP_TX_PAD_EN
        return (n < 18) ? 18 : n;
`else
        return n;
`endif
    endfunction

    // Upstream source: bytes first+i, holds each byte until accepted.
    task automatic drive_stream(input int n, input logic [7:0] first, input int close_at,
                                input logic last_at_end);
        logic acc;
        for (int i = 0; i < n; i++) begin
            sif.s_data  = first + 8'(i);
            sif.s_valid = 1'b1;
            sif.s_last  = last_at_end && (i == n - 1);
            acc = 1'b0;
            for (int w = 0; w < 4000; w++) begin
                acc = sif.s_ready;
                tick();
                if (acc) break;
            end
            if (!acc) begin
                chk("stream_stall", 32'(acc), 32'd1);
                sif.s_valid = 1'b0;
                sif.s_last  = 1'b0;
                return;
            end
            if ((last_at_end && i == n - 1) || i == close_at) begin
                chk("s_ready_drop", 32'(sif.s_ready), 32'd0);
            end
        end
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
    endtask

    // mac_top side of one frame: CHECK handling, TX RAM write, end and gap.
    task automatic sink_frame(input frame_t v);
        int         bad;
        int         cnt;
        int         derr;
        logic [7:0] e;
        almost_full   = (v.af_cycles > 0);
        mac_not_exist = v.mne;
        for (int w = 0; w < 4000 && sif.s_ready; w++) tick();
        chk("frame_close", 32'(sif.s_ready), 32'd0);
        if (v.mne) begin
            tick();
            chk("arp_req_resend", 32'(arp_request_req), 32'd1);
            mac_not_exist = 1'b0;
            tick();
            chk("arp_req_one_cycle", 32'(arp_request_req), 32'd0);
            mac_send_end = 1'b1;
            tick();
            mac_send_end = 1'b0;
            repeat (3) tick();
            arp_found = 1'b1;
            tick();
            arp_found = 1'b0;
            chk("collect_skipped", 32'(sif.s_ready), 32'd0);
        end
        if (v.af_cycles > 0) begin
            bad = 0;
            for (int k = 0; k < v.af_cycles; k++) begin
                tick();
                if (udp_tx_req !== 1'b0) bad++;
            end
            chk("af_hold", 32'(bad), 32'd0);
            almost_full = 1'b0;
        end
        tick();
        chk("udp_tx_req", 32'(udp_tx_req), 32'd1);
        chk("length", 32'(udp_send_data_length), 32'(v.exp_len));
        tick();
        chk("udp_tx_req_pulse", 32'(udp_tx_req), 32'd0);
        repeat (3) tick();
        udp_ram_data_req = 1'b1;
        tick();
        udp_ram_data_req = 1'b0;
        chk("wr_latency_early", 32'(ram_wr_en), 32'd0);
        tick();
        chk("wr_first_byte", 32'(ram_wr_en), 32'd1);
        cnt  = 0;
        derr = 0;
        while (ram_wr_en === 1'b1 && cnt < 2100) begin
            e = (cnt < v.n_bytes) ? (v.first + 8'(cnt)) : 8'h00;
            if (ram_wr_data !== e) derr++;
            if (v.early_end) udp_tx_end = (cnt == 0);
            tick();
            cnt++;
        end
        udp_tx_end = 1'b0;
        chk("wr_count", 32'(cnt), 32'(v.exp_len));
        chk("wr_data_errs", 32'(derr), 32'd0);
        if (v.early_end) begin
            repeat (90) tick();
        end else begin
            repeat (4) tick();
            udp_tx_end = 1'b1;
            tick();
            udp_tx_end = 1'b0;
            repeat (89) tick();
        end
        chk("gap_last_cycle", 32'(sif.s_ready), 32'd0);
        tick();
        chk("gap_done_ready", 32'(sif.s_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int     hi;
        frame_t fc1;
        frame_t fc2;
        frame_t fr;

        vecs[0] = '{20, 8'h01, 0,  1'b0, 1'b0, exp_len_f(20)};
        vecs[1] = '{20, 8'h01, 50, 1'b0, 1'b0, exp_len_f(20)};
        vecs[2] = '{20, 8'h01, 0,  1'b1, 1'b0, exp_len_f(20)};
        vecs[3] = '{20, 8'hF5, 0,  1'b0, 1'b1, exp_len_f(20)};
        vecs[4] = '{5,  8'h30, 0,  1'b0, 1'b0, exp_len_f(5)};
        vecs[5] = '{1,  8'hA5, 0,  1'b0, 1'b0, exp_len_f(1)};

        rst              = 1'b1;
        mac_send_end     = 1'b0;
        arp_found        = 1'b0;
        mac_not_exist    = 1'b0;
        almost_full      = 1'b0;
        udp_ram_data_req = 1'b0;
        udp_tx_end       = 1'b0;
        sif.s_data       = 8'h00;
        sif.s_valid      = 1'b0;
        sif.s_last       = 1'b0;
        repeat (3) tick();
        chk("rst_s_ready", 32'(sif.s_ready), 32'd0);
        chk("rst_arp_req", 32'(arp_request_req), 32'd0);
        chk("rst_udp_tx_req", 32'(udp_tx_req), 32'd0);
        chk("rst_ram_wr_en", 32'(ram_wr_en), 32'd0);
        chk("rst_ram_wr_data", 32'(ram_wr_data), 32'd0);
        chk("rst_length", 32'(udp_send_data_length), 32'd0);

        // IDLE delay: pulse on the 256th clock after reset release.
        rst = 1'b0;
        hi = 0;
        for (int k = 0; k < 255; k++) begin
            tick();
            if (arp_request_req !== 1'b0) hi++;
        end
        chk("idle_no_early_arp", 32'(hi), 32'd0);
        tick();
        chk("idle_arp_req", 32'(arp_request_req), 32'd1);
        tick();
        chk("arp_req_single", 32'(arp_request_req), 32'd0);

        // ARP timeout: second request 256 clocks after entering ARP_WAIT.
        mac_send_end = 1'b1;
        tick();
        mac_send_end = 1'b0;
        hi = 0;
        for (int k = 0; k < 255; k++) begin
            tick();
            if (arp_request_req !== 1'b0) hi++;
        end
        chk("arp_wait_no_early", 32'(hi), 32'd0);
        tick();
        chk("arp_timeout_req", 32'(arp_request_req), 32'd1);
        tick();
        mac_send_end = 1'b1;
        tick();
        mac_send_end = 1'b0;
        repeat (9) tick();
        arp_found = 1'b1;
        tick();
        arp_found = 1'b0;
        chk("collect_ready", 32'(sif.s_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            fork
                drive_stream(vecs[i].n_bytes, vecs[i].first, -1, 1'b1);
                sink_frame(vecs[i]);
            join
        end

        // 1500-byte stream: forced close at 1472, remaining 28 bytes follow.
        fc1 = '{1472, 8'h01, 0, 1'b0, 1'b0, 1472};
        fc2 = '{28,   8'hC1, 0, 1'b0, 1'b0, exp_len_f(28)};
        fork
            drive_stream(1500, 8'h01, 1471, 1'b1);
            begin
                sink_frame(fc1);
                sink_frame(fc2);
            end
        join

        // Reset mid-frame discards the partial payload.
        sif.s_valid = 1'b1;
        sif.s_last  = 1'b0;
        for (int k = 0; k < 7; k++) begin
            sif.s_data = 8'h70 + 8'(k);
            tick();
        end
        sif.s_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk("midrst_s_ready", 32'(sif.s_ready), 32'd0);
        chk("midrst_udp_tx_req", 32'(udp_tx_req), 32'd0);
        chk("midrst_length", 32'(udp_send_data_length), 32'd0);
        rst = 1'b0;
        hi = 0;
        for (int k = 0; k < 255; k++) begin
            tick();
            if (arp_request_req !== 1'b0 || udp_tx_req !== 1'b0) hi++;
        end
        chk("midrst_no_pulse", 32'(hi), 32'd0);
        tick();
        chk("midrst_arp_req", 32'(arp_request_req), 32'd1);
        tick();
        mac_send_end = 1'b1;
        tick();
        mac_send_end = 1'b0;
        repeat (2) tick();
        arp_found = 1'b1;
        tick();
        arp_found = 1'b0;
        chk("midrst_collect", 32'(sif.s_ready), 32'd1);
        fr = '{3, 8'h55, 0, 1'b0, 1'b0, exp_len_f(3)};
        fork
            drive_stream(fr.n_bytes, fr.first, -1, 1'b1);
            sink_frame(fr);
        join

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/udp_stream_sender.md
Name: udp_stream_sender

Overview:
- Transmit-side counterpart to the UDP receive/loopback controller; runs on the MAC TX domain and feeds the mac_top transmit interface.
- Accepts a byte stream with frame delimiters and buffers one payload.
- Resolves the destination MAC via ARP when needed, requests a UDP send, then writes the buffered payload into mac_top's TX RAM on demand.
- Throttles on almost_full and enforces an inter-frame gap.

Parameters:
- MAX_PAYLOAD, 1472, payload buffer depth in bytes; a frame is force-closed at this size.
- ARP_RETRY_CYCLES, 256, ARP_WAIT timeout and IDLE start delay, in clocks.
- GAP_CYCLES, 90, idle clocks between udp_tx_end and the next request.
- MIN_PAYLOAD, 18, minimum payload length, used only with the pad option.

Ports:
- gmii_tx_clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- s_data  in  8  payload byte
- s_valid  in  1  byte valid
- s_last  in  1  last byte of frame, qualified by s_valid
- s_ready  out  1  sender can accept a byte
- arp_request_req  out  1  one-cycle ARP request pulse
- mac_send_end  in  1  ARP frame transmitted
- arp_found  in  1  ARP reply received
- mac_not_exist  in  1  destination MAC unknown
- almost_full  in  1  MAC TX path near full
- udp_tx_req  out  1  one-cycle UDP send request pulse
- udp_ram_data_req  in  1  mac_top ready for payload bytes
- ram_wr_data  out  8  payload byte to TX RAM
- ram_wr_en  out  1  payload byte strobe
- udp_send_data_length  out  16  payload length of current frame
- udp_tx_end  in  1  UDP frame fully transmitted

Behaviour:
- Reset state is IDLE, with all outputs 0: s_ready, arp_request_req, udp_tx_req, ram_wr_en, ram_wr_data, udp_send_data_length.
- Reset clears the buffer write/read pointers and the cycle counter. Reset mid-frame discards the partial payload; no pulse is emitted.
- IDLE: counts to ARP_RETRY_CYCLES, then goes to ARP_REQ.
- ARP_REQ: arp_request_req=1 for exactly one cycle, then ARP_SEND.
- ARP_SEND: waits for mac_send_end, then ARP_WAIT.
- ARP_WAIT: arp_found → COLLECT. Timeout at ARP_RETRY_CYCLES → ARP_REQ. arp_found has priority if both occur in the same cycle.
- COLLECT: s_ready=1. Each s_valid&s_ready writes s_data at wr_ptr and increments wr_ptr.
  - Leave to CHECK when s_last is accepted, or when wr_ptr reaches MAX_PAYLOAD (forced close). s_ready drops the cycle after the closing byte.
  - s_valid with s_ready=0 is held by upstream; bytes are not dropped.
- CHECK: s_ready=0.
  - mac_not_exist → ARP_REQ; the buffer is preserved and resent after resolution, with COLLECT skipped when length is nonzero.
  - Otherwise, almost_full → stay in CHECK.
  - Otherwise latch udp_send_data_length=wr_ptr and go to GEN_REQ.
- GEN_REQ: udp_tx_req=1 for one cycle, then WAIT_REQ.
- WAIT_REQ: on udp_ram_data_req go to WRITE_RAM, with rd_ptr=0.
- WRITE_RAM: buffer read is synchronous, one cycle latency.
  - ram_wr_en is high exactly udp_send_data_length consecutive cycles, aligned with ram_wr_data; the first byte appears 2 cycles after udp_ram_data_req is seen.
  - After the last byte go to SEND.
- SEND: waits for udp_tx_end, then GAP; udp_tx_end arriving during WRITE_RAM is registered and honoured.
- GAP: counts GAP_CYCLES, clears the buffer pointers, then COLLECT.
- Counter: 16-bit. It clears on every state change and saturates rather than wraps.
- Width rules: udp_send_data_length is a zero-extended 11-bit pointer. Length 0 is impossible, since s_last is byte-qualified.

Optional Feature:
- UDP_TX_PAD_EN defined: when the latched length < MIN_PAYLOAD, udp_send_data_length=MIN_PAYLOAD and WRITE_RAM emits 0x00 bytes after the real data.
- UDP_TX_PAD_EN undefined: the length equals the bytes received, and there is no padding logic.

Decomposition:
- Package udp_tx_pkg: one-hot state encodings (IDLE, ARP_REQ, ARP_SEND, ARP_WAIT, COLLECT, CHECK, GEN_REQ, WAIT_REQ, WRITE_RAM, SEND, GAP) and pointer-width constant.
- Sub-module udp_tx_payload_buf: simple dual-port byte RAM, MAX_PAYLOAD deep, registered read.

Test Plan:
- Reset, then arp_found 10 cycles after mac_send_end → one arp_request_req pulse at cycle 256, then s_ready=1 in COLLECT.
- ARP timeout: no arp_found → second arp_request_req 256 cycles after ARP_WAIT entry.
- 20-byte stream 0x01..0x14 with s_last → udp_send_data_length=20, one udp_tx_req, 20 ram_wr_en cycles carrying 0x01..0x14, then GAP of 90 cycles after udp_tx_end.
- almost_full held for 50 cycles in CHECK → udp_tx_req delayed until 1 cycle after release. mac_not_exist in CHECK → ARP sequence, then the same 20 bytes resent.
- 1500-byte stream without s_last → forced close at 1472, s_ready low, remaining 28 bytes form the next frame.
- With UDP_TX_PAD_EN: 5-byte frame → length 18, bytes 6..18 are 0x00. Without it: length 5.
